// File: rtl/uart_bps_gen.sv
// Baud-tick generator for one UART TX or RX path: bit-period tick (start or
// mid-bit phase), OSR oversample ticks per bit and a divisor sanity flag.
module uart_bps_gen #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned OSR    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Count_Sig,
  input  logic [2:0]       BAUD_SEL,
  input  logic [DIV_W-1:0] DIV_CUSTOM,
  input  logic             PHASE_MID,
  output logic             BPS_CLK,
  output logic             OS_CLK,
  output logic             Cfg_Err
);

  function automatic logic [DIV_W-1:0] baud_div(input int unsigned baud);
    return DIV_W'((CLK_HZ + baud / 2) / baud);
  endfunction

  localparam logic [DIV_W-1:0] DIV_0 = baud_div(9600);
  localparam logic [DIV_W-1:0] DIV_1 = baud_div(19200);
  localparam logic [DIV_W-1:0] DIV_2 = baud_div(38400);
  localparam logic [DIV_W-1:0] DIV_3 = baud_div(57600);
  localparam logic [DIV_W-1:0] DIV_4 = baud_div(115200);
  localparam logic [DIV_W-1:0] DIV_5 = baud_div(230400);

  localparam int unsigned      OSI_W   = $clog2(OSR + 1);
  localparam logic [OSI_W-1:0] OS_MAX  = OSI_W'(OSR);
  localparam logic [DIV_W-1:0] OSR_DIV = DIV_W'(OSR);
  localparam logic [DIV_W-1:0] ERR_LIM = DIV_W'(2 * OSR);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

  logic [DIV_W-1:0] sel_div;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] os_raw;
  logic [DIV_W-1:0] os_div;
  logic [DIV_W-1:0] target;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] os_cnt;
  logic [OSI_W-1:0] os_idx;
  logic             bit_wrap;
  logic             os_wrap;

  always_comb begin
    sel_div = DIV_0;
    unique case (BAUD_SEL)
      3'd0:    sel_div = DIV_0;
      3'd1:    sel_div = DIV_1;
      3'd2:    sel_div = DIV_2;
      3'd3:    sel_div = DIV_3;
      3'd4:    sel_div = DIV_4;
      3'd5:    sel_div = DIV_5;
      default: sel_div = (DIV_CUSTOM < DIV_MIN) ? DIV_MIN : DIV_CUSTOM;
    endcase
  end

  always_comb begin
    os_raw   = div_q / OSR_DIV;
    os_div   = (os_raw == '0) ? DIV_W'(1) : os_raw;
    target   = PHASE_MID ? (div_q >> 1) : '0;
    bit_wrap = Count_Sig && (cnt == div_q - DIV_W'(1));
    os_wrap  = (os_cnt == os_div - DIV_W'(1));
  end

  // div_q only reloads while idle or at a bit boundary, so a rate change
  // never shortens or stretches the period in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q   <= DIV_0;
      cnt     <= '0;
      os_cnt  <= '0;
      os_idx  <= '0;
      BPS_CLK <= 1'b0;
      OS_CLK  <= 1'b0;
      Cfg_Err <= 1'b0;
    end else begin
      if (!Count_Sig || bit_wrap) begin
        div_q  <= sel_div;
        cnt    <= '0;
        os_cnt <= '0;
        os_idx <= '0;
      end else begin
        cnt    <= cnt + DIV_W'(1);
        os_cnt <= os_wrap ? '0 : os_cnt + DIV_W'(1);
        if (os_wrap && (os_idx != OS_MAX))
          os_idx <= os_idx + OSI_W'(1);
      end
      BPS_CLK <= Count_Sig && (cnt == target);
      OS_CLK  <= Count_Sig && (os_cnt == '0) && (os_idx < OS_MAX);
      Cfg_Err <= (div_q < ERR_LIM);
    end
  end

endmodule
